// File: rtl/ntt_seq.sv
// ntt_seq -- sequential streaming N-point number-theoretic transform over Z_m.
//
// Loads N coefficients x[0..N-1] over a valid/ready stream, then for each
// output index k evaluates X[k] = sum_j x[j] * w^(j*k) mod m with one modular
// multiply-accumulate per cycle, and streams X[0..N-1] out in natural order.
//
// Optional feature macro: NTT_INVERSE_EN
//   defined   -> inv=1 (sampled with x[0]) selects inverse mode; every result
//                passes through a SCALE cycle that multiplies it by n_inv.
//   undefined -> no SCALE state or scaling multiplier; inv/n_inv are ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   coefficient valid
//   in_ready   coefficient accepted (LOAD state only)
//   in_data    coefficient x[j], j = arrival order
//   omega      primitive N-th root of unity (sampled with x[0])
//   mod        modulus m >= 2 (sampled with x[0])
//   inv        inverse select (sampled with x[0])
//   n_inv      N^-1 mod m (sampled with x[0])
//   out_valid  result valid
//   out_ready  downstream accepts result
//   out_data   X[k], always < m
//   out_index  k of the current result
//   out_last   high with out_valid when k = N-1
//   busy       high in any state other than LOAD
module ntt_seq #(
  parameter int N = 8,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic [W-1:0]         omega,
  input  logic [W-1:0]         mod,
  input  logic                 inv,
  input  logic [W-1:0]         n_inv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 out_last,
  output logic                 busy
);

  localparam int LOGN = $clog2(N);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
  localparam logic [W-1:0]    ONE  = W'(1);

`ifdef NTT_INVERSE_EN
  typedef enum logic [1:0] {S_LOAD, S_ROW, S_SCALE, S_EMIT} state_t;
`else
  typedef enum logic [1:0] {S_LOAD, S_ROW, S_EMIT} state_t;
`endif

  state_t state, state_next;

  logic [W-1:0]    coef_mem [N];
  logic [W-1:0]    omega_r, mod_r, acc, tw, wk;
  logic [LOGN-1:0] j, k;
  logic            in_fire, out_fire;

`ifdef NTT_INVERSE_EN
  logic            inv_r;
  logic [W-1:0]    n_inv_r;
`else
  // Forward-only build: the inverse-mode inputs are intentionally unused.
  logic            unused_cfg;
  assign unused_cfg = ^{inv, n_inv};
`endif

  // Full-width product reduced by the modulus.
  function automatic logic [W-1:0] mul_mod(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return W'(prod % {{W{1'b0}}, m});
  endfunction

  // Both operands are already < m, so one conditional subtract suffices.
  function automatic logic [W-1:0] add_mod(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m}) sum = sum - {1'b0, m};
    return W'(sum);
  endfunction

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_LOAD);
  assign out_valid = (state == S_EMIT);
  assign out_data  = out_valid ? acc : '0;
  assign out_index = k;
  assign out_last  = out_valid && (k == LAST);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: if (in_fire && j == LAST) state_next = S_ROW;
      S_ROW: begin
        if (j == LAST) begin
`ifdef NTT_INVERSE_EN
          state_next = inv_r ? S_SCALE : S_EMIT;
`else
          state_next = S_EMIT;
`endif
        end
      end
`ifdef NTT_INVERSE_EN
      S_SCALE: state_next = S_EMIT;
`endif
      S_EMIT: if (out_ready) state_next = (k == LAST) ? S_LOAD : S_ROW;
      default: state_next = S_LOAD;
    endcase
  end

  // NOTE: the coefficient buffer has no reset; every entry is rewritten by
  // the load phase before ROW reads it, so reset would only cost area.
  always_ff @(posedge clk) begin
    if (!rst && in_fire) coef_mem[j] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      j       <= '0;
      k       <= '0;
      acc     <= '0;
      tw      <= ONE;
      wk      <= ONE;
      omega_r <= '0;
      // Non-zero so the reducers never see a zero divisor before a frame.
      mod_r   <= ONE;
`ifdef NTT_INVERSE_EN
      inv_r   <= 1'b0;
      n_inv_r <= '0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            j <= j + 1'b1;
            if (j == '0) begin
              omega_r <= omega;
              mod_r   <= mod;
`ifdef NTT_INVERSE_EN
              inv_r   <= inv;
              n_inv_r <= n_inv;
`endif
            end
            if (j == LAST) begin
              j   <= '0;
              k   <= '0;
              acc <= '0;
              tw  <= ONE;
              wk  <= ONE;
            end
          end
        end
        S_ROW: begin
          // tw walks w^(j*k) along the row; wk = w^k is fixed for this row.
          acc <= add_mod(acc, mul_mod(coef_mem[j], tw, mod_r), mod_r);
          tw  <= mul_mod(tw, wk, mod_r);
          j   <= (j == LAST) ? '0 : j + 1'b1;
        end
`ifdef NTT_INVERSE_EN
        S_SCALE: acc <= mul_mod(acc, n_inv_r, mod_r);
`endif
        S_EMIT: begin
          if (out_fire) begin
            if (k == LAST) begin
              j <= '0;
            end else begin
              k   <= k + 1'b1;
              wk  <= mul_mod(wk, omega_r, mod_r);
              acc <= '0;
              tw  <= ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_seq.sv
// tb_ntt_seq -- directed self-checking bench for ntt_seq (N=8, W=8).
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected values are hand-computed for m=17 (w=9 forward, w=2 inverse).
module tb_ntt_seq;

  typedef logic [7:0] vec_t [8];

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, inv, out_valid, out_ready, out_last, busy;
  logic [7:0] in_data, omega, mod, n_inv, out_data;
  logic [2:0] out_index;

  int n_checks = 0;
  int n_fail   = 0;

  ntt_seq #(.N(8), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .omega     (omega),
    .mod       (mod),
    .inv       (inv),
    .n_inv     (n_inv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Feed eight coefficients; t_last is the falling edge of the cycle whose
  // rising edge accepted the final coefficient.
  task automatic drive_frame(input vec_t xs, input logic [7:0] om, input logic [7:0] md,
                             input logic iv, input logic [7:0] ni, output time t_last);
    int w;
    omega = om;
    mod   = md;
    inv   = iv;
    n_inv = ni;
    t_last = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = xs[i];
      w = 0;
      while (!in_ready && w < 40) begin
        @(negedge clk);
        w++;
      end
      check("in_ready_load", in_ready, 1);
      t_last = $time;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Receive eight results; optionally hold out_ready low for 5 cycles at stall_k.
  task automatic collect(input vec_t exp_v, input int latency, input int period,
                         input int stall_k, input time t_last);
    int  w;
    time t_prev;
    t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      while (!out_valid && w < 60) begin
        @(negedge clk);
        w++;
      end
      check("out_valid_seen", out_valid, 1);
      if (k == 0) check("latency", int'(($time - t_last) / 10), latency);
      else        check("period", int'(($time - t_prev) / 10), period + ((k - 1 == stall_k) ? 5 : 0));
      check("out_data", out_data, exp_v[k]);
      check("out_index", out_index, k);
      check("out_last", out_last, (k == 7) ? 1 : 0);
      check("in_ready_busy", in_ready, 0);
      t_prev = $time;
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, exp_v[k]);
          check("stall_index", out_index, k);
          check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_drop", out_valid, 0);
    end
    check("in_ready_after_last", in_ready, 1);
    check("busy_after_last", busy, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  vec_t x1, e1, x_imp, e_imp, x_ones, e_ones, x_inv, e_inv;
  time  t_last;
  int   seen, w;

  initial begin
    x1     = '{8'd3, 8'd1, 8'd2, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0};
    e1     = '{8'd12, 8'd9, 8'd4, 8'd12, 8'd15, 8'd15, 8'd15, 8'd10};
    x_imp  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    e_imp  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    x_ones = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    e_ones = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    x_inv  = e1;
`ifdef NTT_INVERSE_EN
    e_inv  = x1;
`else
    // Unscaled transform with w^-1 returns 8*x mod 17.
    e_inv  = '{8'd7, 8'd8, 8'd16, 8'd14, 8'd0, 8'd0, 8'd0, 8'd0};
`endif

    rst = 1'b1; in_valid = 1'b0; in_data = '0; omega = '0; mod = '0;
    inv = 1'b0; n_inv = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_out_data", out_data, 0);
    check("reset_out_index", out_index, 0);
    check("reset_out_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);

    // Forward transforms.
    drive_frame(x1, 8'd9, 8'd17, 1'b0, 8'd0, t_last);
    collect(e1, 9, 9, -1, t_last);
    drive_frame(x_imp, 8'd9, 8'd17, 1'b0, 8'd0, t_last);
    collect(e_imp, 9, 9, -1, t_last);
    drive_frame(x_ones, 8'd9, 8'd17, 1'b0, 8'd0, t_last);
    collect(e_ones, 9, 9, -1, t_last);

    // Backpressure at k=3.
    drive_frame(x1, 8'd9, 8'd17, 1'b0, 8'd0, t_last);
    collect(e1, 9, 9, 3, t_last);

    // Reset after four accepted inputs.
    omega = 8'd9; mod = 8'd17; inv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = x1[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_load");
    drive_frame(x1, 8'd9, 8'd17, 1'b0, 8'd0, t_last);
    collect(e1, 9, 9, -1, t_last);

    // Reset during the row computation of k=2.
    drive_frame(x1, 8'd9, 8'd17, 1'b0, 8'd0, t_last);
    seen = 0;
    w = 0;
    while (seen < 2 && w < 100) begin
      if (out_valid) seen++;
      if (seen < 2) @(negedge clk);
      w++;
    end
    check("row2_results_seen", seen, 2);
    repeat (2) @(negedge clk);
    check("row2_busy", busy, 1);
    check("row2_index", out_index, 2);
    check("row2_out_valid", out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_row");
    drive_frame(x1, 8'd9, 8'd17, 1'b0, 8'd0, t_last);
    collect(e1, 9, 9, -1, t_last);

    // Inverse request: scaled when the feature is built, plain forward otherwise.
`ifdef NTT_INVERSE_EN
    drive_frame(x_inv, 8'd2, 8'd17, 1'b1, 8'd15, t_last);
    collect(e_inv, 10, 10, -1, t_last);
`else
    drive_frame(x_inv, 8'd2, 8'd17, 1'b1, 8'd15, t_last);
    collect(e_inv, 9, 9, -1, t_last);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ntt_seq.md
# ntt_seq

Parametrised, sequential, streaming N-point number-theoretic transform over Z_mod; the clocked successor to the combinational 8-point naive NTT. Accepts N coefficients over a valid/ready input stream and evaluates X[k] = Σ x[j]·ω^(jk) mod m with one modular multiply-accumulate per cycle. Emits X[0..N-1] in natural order over a valid/ready output stream. Optional inverse mode applies n⁻¹ scaling. Sits between the coefficient source (memory/loader) and downstream pointwise-multiply logic in the NTT datapath.

## Interface
- N, 8, transform length; power of two, ≥2; LOGN = $clog2(N) is a localparam
- W, 8, coefficient/modulus width in bits
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input coefficient valid
- in_ready  out  1  block accepts a coefficient (LOAD state only)
- in_data  in  W  coefficient x[j], j = arrival order 0..N-1; must be < mod
- omega  in  W  primitive N-th root of unity mod m (ω⁻¹ for inverse); sampled with x[0]
- mod  in  W  modulus m ≥ 2; sampled with x[0]
- inv  in  1  inverse-transform select; sampled with x[0] (see Configuration)
- n_inv  in  W  N⁻¹ mod m; sampled with x[0]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  W  X[k], always < m
- out_index  out  LOGN  k of current result
- out_last  out  1  high with out_valid when k = N-1
- busy  out  1  high in any state except LOAD

## Operation
- Storage: N×W coefficient buffer; registers ω, m, inv, n_inv, acc, tw, wk (all W bits), j and k counters (LOGN bits).
- Modular arithmetic: products are 2W bits, reduced by % m; acc + p (both < m) reduced by a single conditional subtract of m.
- States: LOAD → ROW → [SCALE] → EMIT → ROW … → LOAD.
- LOAD: in_ready=1. Handshake fire = in_valid & in_ready writes buf[j], j++. On j=0 fire: latch omega, mod, inv, n_inv. On j=N-1 fire: wk←1, k←0, acc←0, tw←1, j←0 → ROW.
- ROW (N cycles, j=0..N-1): acc ← (acc + buf[j]·tw) mod m; tw ← tw·wk mod m. After j=N-1 → SCALE if inverse active, else EMIT.
- SCALE (1 cycle): acc ← acc·n_inv mod m → EMIT.
- EMIT: out_valid=1, out_data=acc, out_index=k, out_last=(k==N-1). Outputs held stable until out_ready. On fire: if k=N-1 → LOAD, j←0; else k++, wk ← wk·ω mod m, acc←0, tw←1 → ROW.
- in_valid outside LOAD is ignored (in_ready=0). Input values ≥ m, non-primitive ω, or wrong n_inv give unspecified values but no hang.

## Timing
- Reset values: in_ready=1 after reset (state LOAD), out_valid=0, out_data=0, out_index=0, out_last=0, busy=0; j=k=0, acc=0.
- Reset mid-frame (any state) discards the partial frame and any pending result; the first cycle after rst deasserts is LOAD.
- Last input accepted at cycle t → ROW cycles t+1..t+N → out_valid first high at t+N+1 (t+N+2 with SCALE).
- With out_ready held high: one result every N+1 cycles (N+2 with SCALE); total frame N inputs + N·(N+1) cycles.
- out_valid asserts the cycle after ROW/SCALE ends and drops the cycle after the fire; no combinational path from out_ready to out_valid or out_data.
- in_ready rises the cycle after the out_last fire; the next frame cannot overlap the current one.

## Configuration
- NTT_INVERSE_EN defined: inv=1 latches inverse mode; the SCALE state exists and multiplies each result by n_inv.
- Undefined: SCALE state and its multiplier are not built; inv and n_inv are ignored (ports present, unconnected internally); always forward, latency N+1 per result.

## Test plan
- N=8, W=8, m=17, ω=9, x=3,1,2,6,0,0,0,0, out_ready=1 → out_data 12,9,4,12,15,15,15,10 with out_index 0..7; out_last only on index 7; first out_valid 9 cycles after last input.
- Same m/ω, x=1,0,0,0,0,0,0,0 → all eight outputs 1; x=1,1,1,1,1,1,1,1 → 8,0,0,0,0,0,0,0.
- Backpressure: first vector, out_ready low for 5 cycles at k=3 → out_data=12, out_index=3 held stable, no result lost or duplicated, in_ready stays 0 until the index-7 fire.
- Reset after 4 inputs, and again during ROW of k=2 → next cycle in_ready=1, out_valid=0, busy=0; a fresh first-vector frame yields exact expected outputs.
- NTT_INVERSE_EN defined, inv=1, ω=2, n_inv=15, x=12,9,4,12,15,15,15,10 → 3,1,2,6,0,0,0,0, result period 10 cycles. Same stimulus with the macro undefined → forward transform of that vector, period 9.
